// File: rtl/player_clock_counter_if.sv
// Control/status bundle between the game FSM / timer renderer (master) and
// the player clock engine (slave).
interface player_clock_counter_if;
  logic        start;
  logic        turn_done;
  logic        pause;
  logic [15:0] rr_timer;
  logic [15:0] rt_timer;
  logic [15:0] br_timer;
  logic [15:0] bt_timer;
  logic        cur_player;
  logic        red_timeout;
  logic        blk_timeout;
  logic        running;
  logic        warn;

  modport master (
    output start, turn_done, pause,
    input  rr_timer, rt_timer, br_timer, bt_timer,
    input  cur_player, red_timeout, blk_timeout, running, warn
  );

  modport slave (
    input  start, turn_done, pause,
    output rr_timer, rt_timer, br_timer, bt_timer,
    output cur_player, red_timeout, blk_timeout, running, warn
  );
endinterface

// File: rtl/player_clock_counter.sv
// Two-player BCD MM:SS game clock: counts down the active player's round and
// total timers once per second. Optional low-time blink via TIMER_LOW_WARN_EN.
module player_clock_counter #(
  parameter int          TICK_DIV   = 100_000_000,
  parameter logic [15:0] ROUND_INIT = 16'h0100,
  parameter logic [15:0] TOTAL_INIT = 16'h1500
) (
  input  logic                  clk,
  input  logic                  rst,
  player_clock_counter_if.slave pc
);

  typedef enum logic [1:0] {IDLE, RUN_RED, RUN_BLK, TIMEOUT} state_t;

  localparam int             PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

  state_t            state;
  logic [PW-1:0]     presc;
  logic [3:0][15:0]  tmr;       // {bt, br, rt, rr}
  logic              cur;
  logic              red_to;
  logic              blk_to;
  logic              run;

  logic              run_st;
  logic              tick;
  logic              turn;
  logic [1:0]        ridx;
  logic [1:0]        tidx;
  logic [15:0]       dec_round;
  logic [15:0]       dec_total;
  logic              hit_zero;

  // One-second BCD decrement; zero saturates, illegal digits act as zero.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] d0, d1, d2, d3;
    logic       b;
    {d3, d2, d1, d0} = v;
    b = 1'b1;
    if (v == 16'h0000) return 16'h0000;
    if (d0 == 4'd0 || d0 > 4'd9) d0 = 4'd9;
    else begin d0 = d0 - 4'd1; b = 1'b0; end
    if (b) begin
      if (d1 == 4'd0 || d1 > 4'd5) d1 = 4'd5;
      else begin d1 = d1 - 4'd1; b = 1'b0; end
    end
    if (b) begin
      if (d2 == 4'd0 || d2 > 4'd9) d2 = 4'd9;
      else begin d2 = d2 - 4'd1; b = 1'b0; end
    end
    if (b) begin
      if (d3 == 4'd0) return 16'h0000;
      d3 = d3 - 4'd1;
    end
    return {d3, d2, d1, d0};
  endfunction

  assign run_st    = (state == RUN_RED) || (state == RUN_BLK);
  assign tick      = run_st && !pc.pause && (presc == PRESC_MAX);
  assign turn      = run_st && !pc.pause && pc.turn_done;
  assign ridx      = {cur, 1'b0};
  assign tidx      = {cur, 1'b1};
  assign dec_round = bcd_dec(tmr[ridx]);
  assign dec_total = bcd_dec(tmr[tidx]);
  assign hit_zero  = (dec_round == 16'h0000) || (dec_total == 16'h0000);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      presc  <= '0;
      tmr    <= '0;
      cur    <= 1'b0;
      red_to <= 1'b0;
      blk_to <= 1'b0;
      run    <= 1'b0;
    end else if (pc.start) begin
      state  <= RUN_RED;
      presc  <= '0;
      tmr    <= {TOTAL_INIT, ROUND_INIT, TOTAL_INIT, ROUND_INIT};
      cur    <= 1'b0;
      red_to <= 1'b0;
      blk_to <= 1'b0;
      run    <= 1'b1;
    end else if (run_st && !pc.pause) begin
      if (turn) begin
        // A coincident tick is dropped so the mover is never charged for it.
        tmr[ridx] <= ROUND_INIT;
        cur       <= ~cur;
        state     <= cur ? RUN_RED : RUN_BLK;
        presc     <= '0;
      end else if (tick) begin
        presc     <= '0;
        tmr[ridx] <= dec_round;
        tmr[tidx] <= dec_total;
        if (hit_zero) begin
          state <= TIMEOUT;
          run   <= 1'b0;
          if (cur) blk_to <= 1'b1;
          else     red_to <= 1'b1;
        end
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

`ifdef TIMER_LOW_WARN_EN
  localparam int          HALF      = TICK_DIV / 2;
  localparam int          HW        = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [15:0] ROUND_LOW = 16'h0010;

  logic [HW-1:0] hcnt;
  logic          warn_q;
  logic          warn_cond;
  logic          hwrap;

  // BCD order matches binary order, so a plain compare finds <= 00:10.
  assign warn_cond = run_st && (tmr[ridx] <= ROUND_LOW);
  assign hwrap     = (hcnt == HW'(HALF - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt   <= '0;
      warn_q <= 1'b0;
    end else if (pc.start || turn) begin
      hcnt   <= '0;
      warn_q <= 1'b0;
    end else begin
      hcnt <= hwrap ? '0 : hcnt + HW'(1);
      if (!warn_cond) warn_q <= 1'b0;
      else if (hwrap) warn_q <= ~warn_q;
    end
  end

  assign pc.warn = warn_q;
`else
  assign pc.warn = 1'b0;
`endif

  assign pc.rr_timer    = tmr[0];
  assign pc.rt_timer    = tmr[1];
  assign pc.br_timer    = tmr[2];
  assign pc.bt_timer    = tmr[3];
  assign pc.cur_player  = cur;
  assign pc.red_timeout = red_to;
  assign pc.blk_timeout = blk_to;
  assign pc.running     = run;

endmodule
